// File: rtl/tlb_rr_if.sv
// Lookup, fill/flush and response bundle of the round-robin TLB.
// The master drives requests and fills; the slave (the TLB) returns responses and status.
interface tlb_rr_if #(
    parameter int ADDR_W = 32,
    parameter int VPN_W  = 20,
    parameter int PFN_W  = 20,
    parameter int CNT_W  = 16
);
    logic              req_valid;
    logic [ADDR_W-1:0] req_address;
    logic              req_rw;
    logic              req_is_mem;

    logic              fill_valid;
    logic [VPN_W-1:0]  fill_vpn;
    logic [PFN_W-1:0]  fill_pfn;
    logic              fill_p;
    logic              fill_rw;
    logic              fill_pcd;
    logic              flush;

    logic              resp_valid;
    logic [PFN_W-1:0]  resp_pf;
    logic              resp_pcd;
    logic              resp_hit;
    logic              resp_miss;
    logic              resp_prot_exc;
    logic              full;
    logic [CNT_W-1:0]  hit_cnt;
    logic [CNT_W-1:0]  miss_cnt;

    modport master (
        output req_valid, req_address, req_rw, req_is_mem,
        output fill_valid, fill_vpn, fill_pfn, fill_p, fill_rw, fill_pcd, flush,
        input  resp_valid, resp_pf, resp_pcd, resp_hit, resp_miss, resp_prot_exc,
        input  full, hit_cnt, miss_cnt
    );

    modport slave (
        input  req_valid, req_address, req_rw, req_is_mem,
        input  fill_valid, fill_vpn, fill_pfn, fill_p, fill_rw, fill_pcd, flush,
        output resp_valid, resp_pf, resp_pcd, resp_hit, resp_miss, resp_prot_exc,
        output full, hit_cnt, miss_cnt
    );
endinterface

// File: rtl/tlb_rr.sv
// Self-contained TLB with registered one-cycle lookups, duplicate-free fills,
// round-robin eviction, single-cycle flush and saturating hit/miss counters.
module tlb_rr #(
    parameter int ENTRIES = 8,
    parameter int ADDR_W  = 32,
    parameter int VPN_W   = 20,
    parameter int PFN_W   = 20,
    parameter int CNT_W   = 16
) (
    input  logic     clk,
    input  logic     rst_n,
    tlb_rr_if.slave  bus
);
    localparam int IDX_W = $clog2(ENTRIES);

    logic [VPN_W-1:0]   vpn_q [ENTRIES];
    logic [PFN_W-1:0]   pfn_q [ENTRIES];
    logic [ENTRIES-1:0] valid_q;
    logic [ENTRIES-1:0] p_q;
    logic [ENTRIES-1:0] rw_q;
    logic [ENTRIES-1:0] pcd_q;
    logic [IDX_W-1:0]   victim_q;

    logic               resp_valid_q;
    logic [PFN_W-1:0]   resp_pf_q;
    logic               resp_pcd_q;
    logic               resp_hit_q;
    logic               resp_miss_q;
    logic               resp_prot_q;
    logic [CNT_W-1:0]   hit_cnt_q;
    logic [CNT_W-1:0]   miss_cnt_q;

    logic [VPN_W-1:0]   req_vpn;
    logic               lk_match;
    logic [IDX_W-1:0]   lk_idx;
    logic [PFN_W-1:0]   nx_pf;
    logic               nx_pcd;
    logic               nx_hit;
    logic               nx_miss;
    logic               nx_prot;

    logic               fl_match;
    logic [IDX_W-1:0]   fl_midx;
    logic               fl_free;
    logic [IDX_W-1:0]   fl_fidx;
    logic [IDX_W-1:0]   fl_tgt;
    logic               fl_evict;
    logic               fill_en;

    assign req_vpn = bus.req_address[ADDR_W-1 -: VPN_W];

    // Descending scan so the lowest matching index is the one left standing.
    always_comb begin
        lk_match = 1'b0;
        lk_idx   = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (vpn_q[i] == req_vpn)) begin
                lk_match = 1'b1;
                lk_idx   = IDX_W'(i);
            end
        end
    end

    always_comb begin
        nx_pf   = '0;
        nx_pcd  = 1'b0;
        nx_hit  = 1'b0;
        nx_miss = 1'b0;
        nx_prot = 1'b0;
        if (!bus.req_is_mem) begin
            nx_hit = 1'b1;
            nx_pf  = PFN_W'(req_vpn);
        end else if (lk_match && p_q[lk_idx]) begin
            nx_pf  = pfn_q[lk_idx];
            nx_pcd = pcd_q[lk_idx];
            if (bus.req_rw && !rw_q[lk_idx]) begin
                nx_prot = 1'b1;
            end else begin
                nx_hit = 1'b1;
            end
        end else begin
            nx_miss = 1'b1;
        end
    end

    always_comb begin
        fl_match = 1'b0;
        fl_midx  = '0;
        fl_free  = 1'b0;
        fl_fidx  = '0;
        for (int i = ENTRIES - 1; i >= 0; i--) begin
            if (valid_q[i] && (vpn_q[i] == bus.fill_vpn)) begin
                fl_match = 1'b1;
                fl_midx  = IDX_W'(i);
            end
            if (!valid_q[i]) begin
                fl_free = 1'b1;
                fl_fidx = IDX_W'(i);
            end
        end
        fl_evict = 1'b0;
        if (fl_match) begin
            fl_tgt = fl_midx;
        end else if (fl_free) begin
            fl_tgt = fl_fidx;
        end else begin
            fl_tgt   = victim_q;
            fl_evict = 1'b1;
        end
        fill_en = bus.fill_valid && !bus.flush;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            victim_q     <= '0;
            resp_valid_q <= 1'b0;
            resp_pf_q    <= '0;
            resp_pcd_q   <= 1'b0;
            resp_hit_q   <= 1'b0;
            resp_miss_q  <= 1'b0;
            resp_prot_q  <= 1'b0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            resp_valid_q <= bus.req_valid;
            if (bus.req_valid) begin
                resp_pf_q   <= nx_pf;
                resp_pcd_q  <= nx_pcd;
                resp_hit_q  <= nx_hit;
                resp_miss_q <= nx_miss;
                resp_prot_q <= nx_prot;
                if (nx_hit && bus.req_is_mem && (hit_cnt_q != '1)) begin
                    hit_cnt_q <= hit_cnt_q + CNT_W'(1);
                end
                if (nx_miss && (miss_cnt_q != '1)) begin
                    miss_cnt_q <= miss_cnt_q + CNT_W'(1);
                end
            end
            if (bus.flush) begin
                valid_q  <= '0;
                victim_q <= '0;
            end else if (fill_en) begin
                valid_q[fl_tgt] <= 1'b1;
                if (fl_evict) begin
                    victim_q <= victim_q + IDX_W'(1);
                end
            end
        end
    end

    // Translation payload is deliberately left out of reset; valid_q gates it.
    always_ff @(posedge clk) begin
        if (fill_en) begin
            vpn_q[fl_tgt] <= bus.fill_vpn;
            pfn_q[fl_tgt] <= bus.fill_pfn;
            p_q[fl_tgt]   <= bus.fill_p;
            rw_q[fl_tgt]  <= bus.fill_rw;
            pcd_q[fl_tgt] <= bus.fill_pcd;
        end
    end

    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_pf       = resp_pf_q;
    assign bus.resp_pcd      = resp_pcd_q;
    assign bus.resp_hit      = resp_hit_q;
    assign bus.resp_miss     = resp_miss_q;
    assign bus.resp_prot_exc = resp_prot_q;
    assign bus.full          = &valid_q;
    assign bus.hit_cnt       = hit_cnt_q;
    assign bus.miss_cnt      = miss_cnt_q;
endmodule
